// File: rtl/traffic_light_sequencer.sv
// traffic_light_sequencer: main/side-street light controller with a pedestrian
// walk phase. Phases are timed in Tick units. Sensor and WR are sampled only at
// fixed decision edges. WR_Reset hands the walk request back to WalkRegister.
module traffic_light_sequencer #(
  parameter int T_BASE = 6,  // base green duration in ticks (>=1)
  parameter int T_EXT  = 3,  // extension / walk duration in ticks (>=1)
  parameter int T_YEL  = 2,  // yellow duration in ticks (>=1)
  parameter int CNT_W  = 4   // holds max(T_BASE,T_EXT,T_YEL)-1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Tick,
  input  logic       Sensor,
  input  logic       WR,
  input  logic       Prog_Sync,
  output logic       WR_Reset,
  output logic [2:0] Main_Lights,
  output logic [2:0] Side_Lights,
  output logic       Walk_Lamp,
  output logic [2:0] State_Out
);

  typedef enum logic [2:0] {
    MG1  = 3'd0,
    MG2  = 3'd1,
    MY   = 3'd2,
    WALK = 3'd3,
    SG   = 3'd4,
    SY   = 3'd5
  } state_e;

  // One extra bit so an extended side green (T_BASE+T_EXT) always fits.
  localparam int CW = CNT_W + 1;

  localparam logic [CW-1:0] LD_BASE   = CW'(T_BASE - 1);
  localparam logic [CW-1:0] LD_EXT    = CW'(T_EXT - 1);
  localparam logic [CW-1:0] LD_YEL    = CW'(T_YEL - 1);
  localparam logic [CW-1:0] LD_SG_EXT = CW'(T_BASE + T_EXT - 1);

  // Lamp codes, {R,Y,G}.
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_reset_q, wr_reset_d;
  logic            state_legal;
  logic [CW-1:0]   sg_load;

  assign state_legal = (state_q <= SY);
  // Side green length is chosen by the sensor level on the SG entry edge.
  assign sg_load     = Sensor ? LD_SG_EXT : LD_BASE;

  // State register: state, phase counter and the walk-clear pulse.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= MG1;
      cnt_q      <= LD_BASE;
      wr_reset_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_reset_q <= wr_reset_d;
    end
  end

  // Next-state and counter logic: restart strobe first, then illegal-code
  // recovery, then tick-driven countdown and phase transitions.
  // NOTE: every variable gets a default at the top so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (Prog_Sync || !state_legal) begin
      state_d = MG1;
      cnt_d   = LD_BASE;
    end else if (Tick) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else begin
        case (state_q)
          MG1: begin
            state_d = MG2;
            cnt_d   = Sensor ? LD_EXT : LD_BASE;
          end
          MG2: begin
            state_d = MY;
            cnt_d   = LD_YEL;
          end
          MY: begin
            if (WR) begin
              state_d = WALK;
              cnt_d   = LD_EXT;
            end else begin
              state_d = SG;
              cnt_d   = sg_load;
            end
          end
          WALK: begin
            state_d = SG;
            cnt_d   = sg_load;
          end
          SG: begin
            state_d = SY;
            cnt_d   = LD_YEL;
          end
          SY: begin
            state_d = MG1;
            cnt_d   = LD_BASE;
          end
          default: begin
            state_d = MG1;
            cnt_d   = LD_BASE;
          end
        endcase
      end
    end
    // Clear pulse accompanies only the edge that enters WALK.
    wr_reset_d = (state_d == WALK) && (state_q != WALK);
  end

  // Moore lamp decode; anything unexpected shows all-red on both streets.
  always_comb begin
    Main_Lights = LAMP_RED;
    Side_Lights = LAMP_RED;
    Walk_Lamp   = 1'b0;
    case (state_q)
      MG1, MG2: Main_Lights = LAMP_GRN;
      MY:       Main_Lights = LAMP_YEL;
      WALK:     Walk_Lamp   = 1'b1;
      SG:       Side_Lights = LAMP_GRN;
      SY:       Side_Lights = LAMP_YEL;
      default: begin
        Main_Lights = LAMP_RED;
        Side_Lights = LAMP_RED;
      end
    endcase
  end

  assign WR_Reset  = wr_reset_q;
  assign State_Out = state_q;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Testbench for traffic_light_sequencer. The driver pushes the expected phase
// sequence (state, length in ticks, WR_Reset cycles) into a queue; a monitor
// detects each completed phase on State_Out and compares it to the queue head.
module tb_traffic_light_sequencer;

  localparam logic [2:0] S_MG1 = 3'd0, S_MG2 = 3'd1, S_MY = 3'd2,
                         S_WALK = 3'd3, S_SG = 3'd4, S_SY = 3'd5;

  logic       Clk, Reset, Tick, Sensor, WR, Prog_Sync;
  logic       WR_Reset, Walk_Lamp;
  logic [2:0] Main_Lights, Side_Lights, State_Out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] st;
    int         ticks;
    int         pulses;
  } phase_t;

  phase_t exp_q[$];

  traffic_light_sequencer #(
    .T_BASE(6), .T_EXT(3), .T_YEL(2), .CNT_W(4)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Tick(Tick), .Sensor(Sensor), .WR(WR),
    .Prog_Sync(Prog_Sync), .WR_Reset(WR_Reset), .Main_Lights(Main_Lights),
    .Side_Lights(Side_Lights), .Walk_Lamp(Walk_Lamp), .State_Out(State_Out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Spec lamp table: {Main, Side, Walk}.
  function automatic logic [6:0] lamps_for(input logic [2:0] s);
    case (s)
      S_MG1, S_MG2: return {3'b001, 3'b100, 1'b0};
      S_MY:         return {3'b010, 3'b100, 1'b0};
      S_WALK:       return {3'b100, 3'b100, 1'b1};
      S_SG:         return {3'b100, 3'b001, 1'b0};
      S_SY:         return {3'b100, 3'b010, 1'b0};
      default:      return {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  task automatic push(input logic [2:0] st, input int ticks, input int pulses);
    phase_t p;
    p.st = st; p.ticks = ticks; p.pulses = pulses;
    exp_q.push_back(p);
  endtask

  // One plain cycle of the default sequence (no walk).
  task automatic push_plain(input int mg2, input int sg);
    push(S_MG1, 6, 0); push(S_MG2, mg2, 0); push(S_MY, 2, 0);
    push(S_SG, sg, 0); push(S_SY, 2, 0);
  endtask

  task automatic push_walk();
    push(S_MG1, 6, 0); push(S_MG2, 6, 0); push(S_MY, 2, 0);
    push(S_WALK, 3, 1); push(S_SG, 6, 0); push(S_SY, 2, 0);
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // Tick every 10 Clk: nine idle cycles, then one cycle with Tick high.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (9) cyc();
      Tick = 1'b1;
      cyc();
      Tick = 1'b0;
    end
  endtask

  // Stand-in for WalkRegister's clear path.
  always @(negedge Clk) if (WR_Reset) WR = 1'b0;

  // Monitor: closes a phase on every State_Out change and checks lamps always.
  logic [2:0] cur_state = 3'd0;
  int         cur_ticks  = 0;
  int         cur_pulses = 0;

  always @(negedge Clk) begin
    phase_t e;
    if (State_Out != cur_state) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_phase: got state %0d ticks %0d want none at %0t",
                 cur_state, cur_ticks, $time);
      end else begin
        e = exp_q.pop_front();
        check("phase_state", int'(cur_state), int'(e.st));
        check("phase_ticks", cur_ticks, e.ticks);
        check("phase_wr_reset_cycles", cur_pulses, e.pulses);
      end
      cur_state  = State_Out;
      cur_ticks  = 0;
      cur_pulses = 0;
    end
    if (Tick && !Reset) cur_ticks++;
    if (WR_Reset) cur_pulses++;
    check("lamps", int'({Main_Lights, Side_Lights, Walk_Lamp}),
          int'(lamps_for(State_Out)));
    check("never_both_non_red",
          int'((Main_Lights != 3'b100) && (Side_Lights != 3'b100)), 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish want finish by %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1; Tick = 1'b0; Sensor = 1'b0; WR = 1'b0; Prog_Sync = 1'b0;
    #2;
    check("reset_state", int'(State_Out), 0);
    check("reset_main", int'(Main_Lights), 3'b001);
    check("reset_side", int'(Side_Lights), 3'b100);
    check("reset_walk", int'(Walk_Lamp), 0);
    check("reset_wr_reset", int'(WR_Reset), 0);
    repeat (3) cyc();
    Reset = 1'b0;

    // Default cycle, 22 ticks.
    push_plain(6, 6);
    tick(22);

    // Sensor held: MG1+MG2 = 9, SG = 9.
    Sensor = 1'b1;
    push_plain(3, 9);
    tick(22);
    Sensor = 1'b0;

    // WR raised during MG2 -> walk after MY.
    push_walk();
    tick(6);
    WR = 1'b1;
    tick(19);

    // WR raised during SG -> no walk this cycle, walk next cycle.
    push_plain(6, 6);
    push_walk();
    tick(15);
    WR = 1'b1;
    tick(7);
    tick(25);

    // Reset mid-WALK after a fresh WR during WALK; walk served next cycle.
    WR = 1'b1;
    push(S_MG1, 6, 0); push(S_MG2, 6, 0); push(S_MY, 2, 0); push(S_WALK, 1, 1);
    tick(14);
    repeat (3) cyc();
    tick(1);
    WR = 1'b1;
    repeat (2) cyc();
    @(posedge Clk);
    #3;
    Reset = 1'b1;
    #1;
    check("async_reset_state", int'(State_Out), 0);
    check("async_reset_main", int'(Main_Lights), 3'b001);
    check("async_reset_side", int'(Side_Lights), 3'b100);
    check("async_reset_walk", int'(Walk_Lamp), 0);
    check("async_reset_wr_reset", int'(WR_Reset), 0);
    repeat (3) cyc();
    Reset = 1'b0;
    push_walk();
    tick(25);

    // Prog_Sync with Tick while SG counter is 3.
    push(S_MG1, 6, 0); push(S_MG2, 6, 0); push(S_MY, 2, 0); push(S_SG, 3, 0);
    tick(16);
    repeat (9) cyc();
    Tick = 1'b1;
    Prog_Sync = 1'b1;
    cyc();
    Tick = 1'b0;
    Prog_Sync = 1'b0;
    check("prog_sync_state", int'(State_Out), 0);
    check("prog_sync_main", int'(Main_Lights), 3'b001);
    check("prog_sync_side", int'(Side_Lights), 3'b100);
    push_plain(6, 6);
    tick(22);

    // Prog_Sync held for 4 ticks freezes MG1; then a full 6 ticks.
    Prog_Sync = 1'b1;
    push(S_MG1, 10, 0); push(S_MG2, 6, 0); push(S_MY, 2, 0);
    push(S_SG, 6, 0); push(S_SY, 2, 0);
    tick(4);
    Prog_Sync = 1'b0;
    tick(22);

    repeat (5) cyc();
    check("expected_phases_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
